// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and defaults for the nibble-serial adder front end.
package nibble_serial_adder_pkg;

   localparam int NIBBLES_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request, result and external 4-bit adder signals of the nibble-serial adder.
interface nibble_serial_adder_if
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
);
   localparam int W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_cin;

   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_cin;
   logic [3:0]   add_sum;
   logic         add_cout;

   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         zero;
   logic         overflow;

   // slave: the serial adder block
   modport slave (
      input  in_valid, op_a, op_b, op_cin, add_sum, add_cout, res_ready,
      output in_ready, add_a, add_b, add_cin, res_valid, result, cout, zero, overflow
   );

   // master: requester, consumer and the attached adder seen together
   modport master (
      output in_valid, op_a, op_b, op_cin, add_sum, add_cout, res_ready,
      input  in_ready, add_a, add_b, add_cin, res_valid, result, cout, zero, overflow
   );

endinterface

// File: rtl/nibble_serial_adder.sv
// Sequences a W-bit add through an external combinational 4-bit adder,
// one nibble per cycle, LSB first, then holds the result until consumed.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   nibble_serial_adder_if.slave  bus
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       sum_q;
   logic               in_ready_q;
   logic               res_valid_q;
   logic               cout_q;
   logic               zero_q;
   logic               ovf_q;

   logic [3:0]         nib_a;
   logic [3:0]         nib_b;
   logic [W-1:0]       sum_nxt;
   logic               last;

   // Nibble select and the result with the current adder output merged in
   always_comb begin
      nib_a   = '0;
      nib_b   = '0;
      sum_nxt = sum_q;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx == IDX_W'(i)) begin
            nib_a              = a_q[4*i +: 4];
            nib_b              = b_q[4*i +: 4];
            sum_nxt[4*i +: 4]  = bus.add_sum;
         end
      end
   end

   assign last = (idx == IDX_W'(NIBBLES - 1));

   assign bus.add_a     = (state == RUN) ? nib_a : 4'd0;
   assign bus.add_b     = (state == RUN) ? nib_b : 4'd0;
   assign bus.add_cin   = (state == RUN) ? carry : 1'b0;

   assign bus.in_ready  = in_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.result    = sum_q;
   assign bus.cout      = cout_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         carry       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         in_ready_q  <= 1'b1;
         res_valid_q <= 1'b0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.op_a;
                  b_q        <= bus.op_b;
                  carry      <= bus.op_cin;
                  idx        <= '0;
                  sum_q      <= '0;
                  in_ready_q <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               sum_q <= sum_nxt;
               carry <= bus.add_cout;
               idx   <= idx + 1'b1;
               if (last) begin
                  idx         <= '0;
                  state       <= DONE;
                  res_valid_q <= 1'b1;
                  cout_q      <= bus.add_cout;
                  zero_q      <= (sum_nxt == '0);
                  // Same-sign operands producing a differently-signed sum
                  ovf_q       <= (a_q[W-1] == b_q[W-1]) && (sum_nxt[W-1] != a_q[W-1]);
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench: serial adder with a behavioural 4-bit adder attached.
module tb_nibble_serial_adder;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_if #(.NIBBLES(N)) bus ();

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign {bus.add_cout, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] res;
      logic        co;
      logic        z;
      logic        ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issues one add, checks the per-cycle adder drive and latency; leaves DONE pending
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
      logic       car;
      logic [4:0] s;
      int         c;
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.op_a     = a;
      bus.op_b     = b;
      bus.op_cin   = cin;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op_a     = ~a;
      bus.op_b     = ~b;
      bus.op_cin   = ~cin;
      car = cin;
      c   = 0;
      while (c < 20 && bus.res_valid !== 1'b1) begin
         if (c < N) begin
            chk("add_drive", {23'd0, bus.add_a, bus.add_b, bus.add_cin},
                {23'd0, a[4*c +: 4], b[4*c +: 4], car});
            s   = 5'(a[4*c +: 4]) + 5'(b[4*c +: 4]) + 5'(car);
            car = s[4];
         end
         if (c == 1) chk("in_ready_run", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
         c++;
      end
      chk("latency", c, N);
   endtask

   task automatic release_res();
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("res_valid_after_ack", 32'(bus.res_valid), 32'd0);
      chk("in_ready_after_ack", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      vecs[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.op_cin    = 1'b0;
      bus.res_ready = 1'b0;
      rst_n         = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_flags", {29'd0, bus.cout, bus.zero, bus.overflow}, 32'd0);
      chk("rst_add", {23'd0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].cin);
         chk($sformatf("v%0d_result", i), 32'(bus.result), 32'(vecs[i].res));
         chk($sformatf("v%0d_cout", i), 32'(bus.cout), 32'(vecs[i].co));
         chk($sformatf("v%0d_zero", i), 32'(bus.zero), 32'(vecs[i].z));
         chk($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].ovf));
         release_res();
      end

      // Back-pressure in DONE with a competing request present
      do_op(16'h1234, 16'h1111, 1'b0);
      bus.op_a     = 16'hAAAA;
      bus.op_b     = 16'h5555;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_res_valid", 32'(bus.res_valid), 32'd1);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         chk("stall_result", 32'(bus.result), 32'h2345);
         chk("stall_add_idle", {23'd0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
      end
      bus.in_valid = 1'b0;
      release_res();
      chk("stall_no_capture", 32'(bus.result), 32'h2345);

      // Reset mid-operation discards the add
      bus.op_a     = 16'h1234;
      bus.op_b     = 16'h1111;
      bus.op_cin   = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
      chk("abort_result", 32'(bus.result), 32'd0);
      chk("abort_add", {23'd0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      do_op(16'h1234, 16'h1111, 1'b0);
      chk("post_abort_result", 32'(bus.result), 32'h2345);
      release_res();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; the operand width W is 4*NIBBLES.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op_a  input  W  operand A, unsigned or two's complement.
REQ-007 op_b  input  W  operand B.
REQ-008 op_cin  input  1  initial carry-in.
REQ-009 add_a  output  4  A nibble driven to the external 4-bit adder.
REQ-010 add_b  output  4  B nibble driven to the external adder.
REQ-011 add_cin  output  1  carry driven to the external adder.
REQ-012 add_sum  input  4  combinational sum returned by the adder.
REQ-013 add_cout  input  1  combinational carry-out returned by the adder.
REQ-014 res_valid  output  1  result valid.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 result  output  W  assembled sum.
REQ-017 cout  output  1  final carry-out.
REQ-018 zero  output  1  result equals 0.
REQ-019 overflow  output  1  signed overflow.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-021 IDLE: in_ready=1; on in_valid&&in_ready, op_a, op_b and op_cin SHALL be latched, the carry register set to op_cin, the index set to 0, and the FSM moved to RUN.
REQ-022 RUN: add_a and add_b SHALL be nibble[idx] of the latched A and B, and add_cin SHALL be the carry register; each cycle add_sum is written to result nibble[idx], add_cout to the carry register, and idx increments.
REQ-023 Nibbles SHALL be processed LSB first; on the edge that processes idx==NIBBLES-1 the FSM SHALL move to DONE.
REQ-024 Latency: res_valid SHALL be high exactly NIBBLES cycles after the accepting edge.
REQ-025 DONE: res_valid=1; result, cout, zero and overflow SHALL be held stable until res_valid&&res_ready, then the FSM returns to IDLE; there is no same-cycle re-accept.
REQ-026 cout SHALL equal the final carry register; zero SHALL equal (result==0).
REQ-027 overflow SHALL equal (A[W-1]==B[W-1]) && (result[W-1]!=A[W-1]); op_cin is included in the sum.
REQ-028 Outside RUN, add_a, add_b and add_cin SHALL be 0.
REQ-029 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored.
REQ-030 res_ready outside DONE SHALL be ignored.
REQ-031 The block SHALL sample add_sum and add_cout in the same cycle it drives add_a, add_b and add_cin, since the adder is combinational.

Reset
REQ-032 When rst_n==0 at a clock edge: state=IDLE, idx=0, carry=0, and result, cout, zero, overflow and res_valid all 0.
REQ-033 A reset asserted in RUN or DONE SHALL abort the operation and discard it; in_ready=1 on the first cycle after release.

Structure
REQ-034 The package nibble_serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default NIBBLES constant.
REQ-035 There SHALL be no internal sub-module; the existing 4-bit adder SHALL be instantiated beside this block by the parent and wired via add_*.

Verification (NIBBLES=4, real adder attached)
REQ-036 0x0001+0x0002, cin=0 -> result=0x0003, cout=0, zero=0, overflow=0; res_valid exactly 4 cycles after accept.
REQ-037 0xFFFF+0x0001, cin=0 -> result=0x0000, cout=1, zero=1, overflow=0.
REQ-038 0x7FFF+0x0001, cin=0 -> result=0x8000, cout=0, overflow=1; 0x8000+0x8000, cin=1 -> result=0x0001, cout=1, overflow=1.
REQ-039 res_ready held low for 3 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no new capture; the result is accepted on the 4th cycle and in_ready=1 on the next.
REQ-040 rst_n=0 after 2 RUN cycles of 0x1234+0x1111 -> next cycle IDLE, res_valid=0, result=0, add_* =0, in_ready=1; a following 0x1234+0x1111 -> 0x2345.
